debounce_bank: RTL and testbench

DEBOUNCE_BANK -- requirements
Module: debounce_bank

---
 rtl/debounce_bank.sv | 75 +++++++
 tb/tb_debounce_bank.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/debounce_bank.sv
// Multi-channel switch debouncer: per-channel 2-flop synchronizer, stability counter,
// registered debounced level and one-cycle rise/fall pulses.
module debounce_bank #(
  parameter int unsigned      N_CH        = 4,
  parameter int unsigned      CLK_HZ      = 50_000_000,
  parameter int unsigned      DEBOUNCE_MS = 10,
  parameter logic [N_CH-1:0]  RESET_VAL   = '1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] sw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            any_change
);

  localparam int unsigned Timeout = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int unsigned CntW    = ($clog2(Timeout + 1) > 1) ? $clog2(Timeout + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

  logic [N_CH-1:0]           sync1_q;
  logic [N_CH-1:0]           s_q;
  logic [N_CH-1:0]           level_q, level_d;
  logic [N_CH-1:0]           rise_q, rise_d;
  logic [N_CH-1:0]           fall_q, fall_d;
  logic                      any_q;
  logic [N_CH-1:0][CntW-1:0] cnt_q, cnt_d;

  // Counter only advances while the synchronized input disagrees with the debounced level;
  // any agreeing cycle restarts the window.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    cnt_d   = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (s_q[i] != level_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          level_d[i] = s_q[i];
          rise_d[i]  = s_q[i];
          fall_d[i]  = ~s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RESET_VAL;
      s_q     <= RESET_VAL;
      level_q <= RESET_VAL;
      rise_q  <= '0;
      fall_q  <= '0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw_in;
      s_q     <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      any_q   <= |(rise_d | fall_d);
      cnt_q   <= cnt_d;
    end
  end

  assign level_out  = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;
  assign any_change = any_q;

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: two instances (stability windows of 4 and 1 cycles)
// share stimulus; a window-based reference model predicts every level change.
module tb_debounce_bank;

  localparam logic [3:0] RV = 4'hF;

  typedef struct {
    int         edge_i;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sw_in = RV;

  logic [3:0] lo4, ri4, fa4, lo1, ri1, fa1;
  logic       ac4, ac1;

  int checks = 0;
  int errors = 0;

  debounce_bank #(
    .N_CH(4), .CLK_HZ(1000), .DEBOUNCE_MS(4), .RESET_VAL(RV)
  ) dut4 (
    .clk(clk), .rst(rst), .sw_in(sw_in), .level_out(lo4),
    .rise_pulse(ri4), .fall_pulse(fa4), .any_change(ac4)
  );

  debounce_bank #(
    .N_CH(4), .CLK_HZ(1000), .DEBOUNCE_MS(1), .RESET_VAL(RV)
  ) dut1 (
    .clk(clk), .rst(rst), .sw_in(sw_in), .level_out(lo1),
    .rise_pulse(ri1), .fall_pulse(fa1), .any_change(ac1)
  );

  always #5 clk = ~clk;

  // Reference model state
  int         tmo[2] = '{4, 1};
  logic [3:0] lvl_m[2];
  int         last_evt[2][4];
  logic [3:0] s_hist[$];
  logic [3:0] sync1_m, s_m;
  int         edge_cnt = -1;
  exp_t       q0[$];
  exp_t       q1[$];

  initial begin
    lvl_m[0] = RV;
    lvl_m[1] = RV;
    sync1_m  = RV;
    s_m      = RV;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) last_evt[d][c] = 0;
  end

  // A channel's level flips at edge k when the synchronized input disagreed with it on
  // every one of the last T edges, none of which precede the last reset or flip.
  task automatic model_edge(input int d, input int k);
    logic [3:0] ri, fa;
    bit ok;
    exp_t e;
    ri = '0;
    fa = '0;
    if (rst) begin
      lvl_m[d] = RV;
      for (int c = 0; c < 4; c++) last_evt[d][c] = k;
    end else begin
      for (int c = 0; c < 4; c++) begin
        ok = (k - tmo[d] >= last_evt[d][c]);
        for (int j = k - tmo[d]; ok && j < k; j++)
          if (s_hist[j][c] == lvl_m[d][c]) ok = 1'b0;
        if (ok) begin
          if (lvl_m[d][c]) fa[c] = 1'b1;
          else             ri[c] = 1'b1;
          last_evt[d][c] = k;
        end
      end
      lvl_m[d] = (lvl_m[d] | ri) & ~fa;
      if ((ri | fa) != 4'h0) begin
        e.edge_i = k; e.rise = ri; e.fall = fa; e.lvl = lvl_m[d];
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    model_edge(0, edge_cnt);
    model_edge(1, edge_cnt);
    if (rst) begin
      sync1_m = RV;
      s_m     = RV;
    end else begin
      s_m     = sync1_m;
      sync1_m = sw_in;
    end
    s_hist.push_back(s_m);
  end

  task automatic fail(input string name, input int d, input int got, input int exp);
    errors++;
    $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, edge_cnt, got, exp);
  endtask

  task automatic mon(input int d, input logic [3:0] lo, input logic [3:0] ri,
                     input logic [3:0] fa, input logic ac);
    exp_t e;
    bit   have;
    checks++;
    if (lo !== lvl_m[d]) fail("level_out", d, int'(lo), int'(lvl_m[d]));
    checks++;
    if (ac !== |(ri | fa)) fail("any_change_or", d, int'(ac), int'(|(ri | fa)));
    // Drop predicted events whose cycle has passed without the DUT presenting them
    forever begin
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) break;
      e = (d == 0) ? q0[0] : q1[0];
      if (e.edge_i >= edge_cnt) break;
      checks++;
      fail("missed_event", d, 0, e.edge_i);
      if (d == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
    if (ac === 1'b1) begin
      checks++;
      have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
      if (!have) begin
        fail("spurious_event", d, int'({ri, fa}), 0);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (e.edge_i != edge_cnt) fail("event_edge", d, edge_cnt, e.edge_i);
        checks++;
        if (ri !== e.rise) fail("rise_pulse", d, int'(ri), int'(e.rise));
        checks++;
        if (fa !== e.fall) fail("fall_pulse", d, int'(fa), int'(e.fall));
      end
    end
  endtask

  always @(negedge clk) begin
    if (edge_cnt >= 0) begin
      mon(0, lo4, ri4, fa4, ac4);
      mon(1, lo1, ri1, fa1, ac1);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    sw_in = v;
    tick(n);
  endtask

  initial begin
    // Reset with inputs at the reset value
    rst   = 1'b1;
    sw_in = RV;
    tick(2);
    rst = 1'b0;
    hold(RV, 3);
    // Clean falling edge on channel 0
    hold(4'hE, 10);
    // Bounce on channel 1 before settling low
    hold(4'hC, 2);
    hold(4'hE, 2);
    hold(4'hC, 10);
    // Bring channels 2 and 3 low, then release them together
    hold(4'h0, 10);
    hold(4'hC, 10);
    // Reset in the middle of a channel-0 count
    hold(RV, 10);
    sw_in = 4'hE;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hold(4'hE, 10);
    // Randomized runs with occasional resets
    for (int r = 0; r < 150; r++) begin
      if ($urandom_range(0, 31) == 0) begin
        rst = 1'b1;
        hold(4'($urandom_range(0, 15)), $urandom_range(1, 2));
        rst = 1'b0;
      end
      hold(4'($urandom_range(0, 15)), $urandom_range(1, 8));
    end
    hold(sw_in, 12);
    checks++;
    if (q0.size() != 0) fail("pending_events", 0, q0.size(), 0);
    checks++;
    if (q1.size() != 0) fail("pending_events", 1, q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
